// File: rtl/regfile_multiport.sv
// regfile_multiport: N x W register file, NR combinational read ports, write bypass, bulk-clear sweep.
// Optional stored even parity per register when REGFILE_PARITY_EN is defined.
`default_nettype none

module regfile_multiport #(
  parameter int W  = 32,
  parameter int AW = 5,
  parameter int NR = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR*W-1:0]  rdata,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [W-1:0]     wdata,
  input  logic             clr_req,
  output logic             busy,
  output logic             wr_drop,
  output logic [NR-1:0]    perr
);

  localparam int N = 1 << AW;
  localparam logic [AW-1:0] C_LAST = {AW{1'b1}};

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_wr_drop;
  logic [W-1:0]    r_mem [N];
`ifdef REGFILE_PARITY_EN
  logic            r_par [N];
`endif

  logic w_wr_ok;
  assign w_wr_ok = (r_state == S_IDLE) && we && (waddr != '0);

  // Register 0 is never written: writes to it are dropped and the sweep starts at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        r_mem[k] <= '0;
`ifdef REGFILE_PARITY_EN
        r_par[k] <= 1'b0;
`endif
      end
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= we && !w_wr_ok;
      case (r_state)
        S_IDLE: begin
          if (w_wr_ok) begin
            r_mem[waddr] <= wdata;
`ifdef REGFILE_PARITY_EN
            r_par[waddr] <= ^wdata;
`endif
          end
          if (clr_req) begin
            r_state <= S_CLEAR;
            r_cnt   <= AW'(1);
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_mem[r_cnt] <= '0;
`ifdef REGFILE_PARITY_EN
          r_par[r_cnt] <= 1'b0;
`endif
          if (r_cnt == C_LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign wr_drop = r_wr_drop;

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_byp;
    assign w_ra  = raddr[i*AW +: AW];
    assign w_byp = w_wr_ok && (w_ra == waddr);
    assign rdata[i*W +: W] = (w_ra == '0) ? '0 : (w_byp ? wdata : r_mem[w_ra]);
`ifdef REGFILE_PARITY_EN
    assign perr[i] = (w_ra != '0) && !w_byp && ((^r_mem[w_ra]) ^ r_par[w_ra]);
`else
    assign perr[i] = 1'b0;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed checks on a 32x32 dual-port file, random model check on an 8x8 quad-port file.
`default_nettype none

module tb_regfile_multiport;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32 x 32, two read ports
  logic [9:0]  b_raddr;
  logic [63:0] b_rdata;
  logic        b_we, b_clr, b_busy, b_drop;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic [1:0]  b_perr;

  // 8 x 8, four read ports
  logic [11:0] s_raddr;
  logic [31:0] s_rdata;
  logic        s_we, s_clr, s_busy, s_drop;
  logic [2:0]  s_waddr;
  logic [7:0]  s_wdata;
  logic [3:0]  s_perr;

  regfile_multiport u_big (
    .clk(clk), .rst(rst), .raddr(b_raddr), .rdata(b_rdata), .we(b_we), .waddr(b_waddr),
    .wdata(b_wdata), .clr_req(b_clr), .busy(b_busy), .wr_drop(b_drop), .perr(b_perr)
  );

  regfile_multiport #(.W(8), .AW(3), .NR(4)) u_small (
    .clk(clk), .rst(rst), .raddr(s_raddr), .rdata(s_rdata), .we(s_we), .waddr(s_waddr),
    .wdata(s_wdata), .clr_req(s_clr), .busy(s_busy), .wr_drop(s_drop), .perr(s_perr)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference for the small file: contents plus the index the sweep will clear next (0 = idle).
  logic [7:0] m_mem [8];
  int         m_sweep;

  task automatic big_write(input int a, input logic [31:0] d);
    b_we = 1'b1; b_waddr = 5'(a); b_wdata = d;
    tick();
    b_we = 1'b0;
  endtask

  initial begin
    int n;
    b_raddr = '0; b_we = 0; b_waddr = '0; b_wdata = '0; b_clr = 0;
    s_raddr = '0; s_we = 0; s_waddr = '0; s_wdata = '0; s_clr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Asynchronous reset in the middle of a cycle wipes a written register.
    big_write(3, 32'h1);
    b_raddr = {5'd0, 5'd3};
    #1 chk("pre_rst_r3", b_rdata[31:0], 32'h1);
    #1 rst = 1'b1;
    #1 chk("rst_r3", b_rdata[31:0], 32'h0);
    chk("rst_busy", b_busy, 1'b0);
    chk("rst_drop", b_drop, 1'b0);
    chk("rst_small_rdata", s_rdata, 32'h0);
    tick();
    rst = 1'b0;

    // Write to register 0 is dropped.
    b_raddr = '0;
    big_write(0, 32'h5);
    chk("r0_drop", b_drop, 1'b1);
    chk("r0_read", b_rdata[31:0], 32'h0);
    tick();
    chk("drop_clears", b_drop, 1'b0);

    // Same-cycle bypass, then stored value.
    b_we = 1'b1; b_waddr = 5'd3; b_wdata = 32'hDEADBEEF; b_raddr = {5'd0, 5'd3};
    #1 chk("bypass_r3", b_rdata[31:0], 32'hDEADBEEF);
    chk("bypass_r0_port", b_rdata[63:32], 32'h0);
    tick();
    b_we = 1'b0;
    #1 chk("stored_r3", b_rdata[31:0], 32'hDEADBEEF);
    chk("perr_idle", b_perr, 2'b00);

    // Fill, then sweep with a dropped write and a stray clr_req in the middle.
    for (int i = 1; i < 32; i++) big_write(i, 32'(i * 32'h11));
    b_raddr = {5'd31, 5'd7};
    #1 chk("r7_filled", b_rdata[31:0], 32'h77);
    chk("r31_filled", b_rdata[63:32], 32'h20F);
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    n = 0;
    while (b_busy === 1'b1 && n < 100) begin
      n++;
      chk("r31_during_sweep", b_rdata[63:32], 32'h20F);
      if (n == 2) begin b_we = 1'b1; b_waddr = 5'd7; b_wdata = 32'h55; end
      if (n == 3) begin b_we = 1'b0; b_clr = 1'b1; end
      if (n == 4) b_clr = 1'b0;
      #1 if (n == 2) chk("busy_no_bypass", b_rdata[31:0], 32'h77);
      tick();
      if (n == 2) chk("busy_drop", b_drop, 1'b1);
    end
    chk("busy_cycles", 64'(n), 64'd31);
    for (int i = 0; i < 32; i++) begin
      b_raddr = {5'd31, 5'(i)};
      #1 chk("cleared", b_rdata[31:0], 32'h0);
    end
    chk("r31_cleared", b_rdata[63:32], 32'h0);
    tick();
    chk("idle_after_sweep", b_busy, 1'b0);

`ifdef REGFILE_PARITY_EN
    big_write(5, 32'h1);
    b_raddr = {5'd3, 5'd5};
    #1 chk("par_ok", b_perr, 2'b00);
    force u_big.r_mem[5] = 32'h0;
    #1 chk("par_err", b_perr, 2'b01);
    release u_big.r_mem[5];
`else
    b_raddr = {5'd3, 5'd5};
    #1 chk("perr_tied", b_perr, 2'b00);
`endif

    // Random traffic on the quad-port file against the reference.
    for (int k = 0; k < 8; k++) m_mem[k] = '0;
    m_sweep = 0;
    for (int c = 0; c < 1000; c++) begin
      int base;
      logic [7:0] exp;
      logic exp_drop;
      base    = int'($urandom_range(7, 0));
      s_we    = ($urandom_range(3, 0) != 0);
      s_waddr = ($urandom_range(1, 0) == 1) ? 3'((base + 1) % 8) : 3'($urandom_range(7, 0));
      s_wdata = 8'($urandom);
      s_clr   = ($urandom_range(59, 0) == 0);
      for (int p = 0; p < 4; p++) s_raddr[p*3 +: 3] = 3'((base + p) % 8);
      #1;
      for (int p = 0; p < 4; p++) begin
        int a;
        a = (base + p) % 8;
        if (a == 0) exp = 8'h0;
        else if (m_sweep == 0 && s_we && s_waddr != 0 && int'(s_waddr) == a) exp = s_wdata;
        else exp = m_mem[a];
        chk("rand_read", s_rdata[p*8 +: 8], exp);
      end
      chk("rand_perr", s_perr, 4'h0);
      tick();
      if (m_sweep == 0) begin
        exp_drop = s_we && s_waddr == 0;
        if (s_we && s_waddr != 0) m_mem[s_waddr] = s_wdata;
        if (s_clr) m_sweep = 1;
      end else begin
        exp_drop = s_we;
        m_mem[m_sweep] = '0;
        m_sweep = (m_sweep == 7) ? 0 : m_sweep + 1;
      end
      chk("rand_drop", s_drop, exp_drop);
      chk("rand_busy", s_busy, m_sweep != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
